// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// The serial line and all status outputs come straight from flops.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_ODD   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] DataToTransmit,
  input  logic       Transmit,
  output logic       SerialOutputTx,
  output logic       TxBusy,
  output logic       TxDone
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Odd parity sets the bit when the byte holds an even number of ones.
  function automatic logic frame_parity(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [2:0]    state, state_nx;
  logic [CW-1:0] baud_cnt, cnt_nx;
  logic [2:0]    bit_idx, idx_nx;
  logic [2:0]    idx_inc;
  logic [7:0]    shift, shift_nx;
  logic          parity_bit, parity_nx;
  logic          line_nx, busy_nx, done_nx;
  logic          bit_end;

  assign bit_end = (baud_cnt == LAST_CNT);
  assign idx_inc = bit_idx + 3'd1;

  // Next-state, next-line and status computation for the frame FSM.
  always_comb begin
    state_nx  = state;
    cnt_nx    = baud_cnt;
    idx_nx    = bit_idx;
    shift_nx  = shift;
    parity_nx = parity_bit;
    line_nx   = SerialOutputTx;
    busy_nx   = TxBusy;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = ZERO_CNT;
        idx_nx = 3'd0;
        if (Transmit) begin
          shift_nx  = DataToTransmit;
          parity_nx = frame_parity(DataToTransmit, PARITY_ODD);
          state_nx  = START;
          busy_nx   = 1'b1;
          line_nx   = 1'b0;
        end else begin
          busy_nx   = 1'b0;
          line_nx   = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nx   = ZERO_CNT;
          idx_nx   = 3'd0;
          state_nx = DATA;
          line_nx  = shift[0];
        end else begin
          cnt_nx   = baud_cnt + ONE_CNT;
          line_nx  = 1'b0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nx = ZERO_CNT;
          if (bit_idx == 3'd7) begin
            idx_nx   = 3'd0;
            state_nx = PARITY;
            line_nx  = parity_bit;
          end else begin
            idx_nx   = idx_inc;
            line_nx  = shift[idx_inc];
          end
        end else begin
          cnt_nx  = baud_cnt + ONE_CNT;
          line_nx = shift[bit_idx];
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_nx   = ZERO_CNT;
          state_nx = STOP;
          line_nx  = 1'b1;
        end else begin
          cnt_nx   = baud_cnt + ONE_CNT;
          line_nx  = parity_bit;
        end
      end
      STOP: begin
        line_nx = 1'b1;
        if (bit_end) begin
          cnt_nx   = ZERO_CNT;
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx   = baud_cnt + ONE_CNT;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = ZERO_CNT;
        idx_nx   = 3'd0;
        line_nx  = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame with the line high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      baud_cnt       <= ZERO_CNT;
      bit_idx        <= 3'd0;
      shift          <= 8'h00;
      parity_bit     <= 1'b0;
      SerialOutputTx <= 1'b1;
      TxBusy         <= 1'b0;
      TxDone         <= 1'b0;
    end else begin
      state          <= state_nx;
      baud_cnt       <= cnt_nx;
      bit_idx        <= idx_nx;
      shift          <= shift_nx;
      parity_bit     <= parity_nx;
      SerialOutputTx <= line_nx;
      TxBusy         <= busy_nx;
      TxDone         <= done_nx;
    end
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial transmitter that matches the team's UART receiver frame format: 1 start bit (0), 8 data bits LSB first, 1 parity bit (odd by default), 1 stop bit (1).
- Latches a parallel byte on a request, serialises it at a fixed clocks-per-bit rate, and reports busy/done status.
- Sits on the TX side of the UART, driving the serial line that the receiver's SerialDataRx samples.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit; legal range 2..65535.
- PARITY_ODD, 1, 1 = odd parity (total ones in data+parity is odd); 0 = even parity.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- DataToTransmit  in  8  byte to send; sampled only on the accept cycle.
- Transmit  in  1  send request, level-sensitive; accepted only when TxBusy=0.
- SerialOutputTx  out  1  serial line, registered; idles high.
- TxBusy  out  1  high from the accept edge until the frame completes.
- TxDone  out  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset values (asynchronous, while reset=1):
  - SerialOutputTx=1, TxBusy=0, TxDone=0, state=IDLE.
  - Baud counter=0, bit index=0, shift register=0.
- Reset mid-frame aborts the frame: the line returns to 1 immediately and no TxDone pulse is produced.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - SerialOutputTx=1.
  - On an edge with Transmit=1, latch DataToTransmit into the shift register.
  - Compute parity: ^data XOR PARITY_ODD (odd: bit=1 when the data has an even number of ones).
  - Go to START, set TxBusy=1, baud counter=0.
- START: SerialOutputTx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA:
  - SerialOutputTx = shift[bit index], each bit held CLKS_PER_BIT cycles.
  - After bit 7, go to PARITY.
- PARITY: SerialOutputTx = latched parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - SerialOutputTx=1 for CLKS_PER_BIT cycles.
  - On the edge ending the last stop cycle: go to IDLE, TxBusy=0, TxDone=1 for exactly one cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit transition.
  - Width is $clog2(CLKS_PER_BIT).
- Frame timing:
  - The accept edge is edge k, and the start bit begins at that edge.
  - The line is valid for 11*CLKS_PER_BIT cycles.
  - TxDone is high in the cycle following edge k+11*CLKS_PER_BIT.
- Changes to DataToTransmit while TxBusy=1 do not affect the frame in flight.
- Transmit while TxBusy=1 is ignored and does not queue.
- Transmit held high:
  - A new frame is accepted on the first IDLE edge, i.e. the cycle in which TxDone=1.
  - Minimum inter-frame idle is therefore 1 cycle beyond the stop bit.
  - Frames repeat back-to-back.
- Transmit asserted in the same cycle that reset deasserts is accepted on the next rising edge.
- No glitches: SerialOutputTx comes directly from a flop.

Test Plan:
- Reset, then Transmit pulse with DataToTransmit=8'h55, CLKS_PER_BIT=434:
  - Line sequence 0,1,0,1,0,1,0,1,0,1(parity),1(stop), each exactly 434 cycles.
  - TxBusy high for 4774 cycles; a single TxDone pulse.
- DataToTransmit=8'h07 (3 ones):
  - Parity bit = 0 with PARITY_ODD=1.
  - Rerun with PARITY_ODD=0: parity bit = 1.
  - 8'h00 with odd parity: parity bit = 1.
- Transmit held high with 8'hA3:
  - Two consecutive frames, exactly 1 idle-high cycle after the first stop bit.
  - Second frame accepted in the TxDone cycle.
  - Toggling DataToTransmit mid-frame does not alter the first frame.
- Reset asserted mid-DATA (bit 4 of 8'hF0), asynchronous between clock edges:
  - SerialOutputTx=1 and TxBusy=0 before the next clock edge; no TxDone.
  - A fresh frame works after reset release.
- Transmit pulse while TxBusy=1 → ignored; exactly one frame and one TxDone.
- Loopback: SerialOutputTx drives the UART receiver's SerialDataRx; send 8'h55 then 8'hC3.
  - Receiver raises RxInterrupt with ReceivedData=8'h55 and ParityError=0.
  - After ClearInterrupt, the second frame yields ReceivedData=8'hC3 and ParityError=0.
